// File: rtl/threshold_pkg.sv
// Shared definitions for the frame binarisation sequencer.
//   - state_t      : sequencer states (IDLE, RUN, DRAIN, DONE)
//   - PIX_FG/PIX_BG: output pixel values for foreground/background
//   - res_entry_t  : one buffered result {data, addr, eol}
//   - binarise()   : the unsigned pixel-vs-threshold compare
// The struct field widths are fixed here, so the top-level PIX_W/ADDR_W
// parameters must be left at TH_PIX_W/TH_ADDR_W.
package threshold_pkg;

    localparam int TH_PIX_W  = 8;
    localparam int TH_ADDR_W = 19;

    localparam logic [TH_PIX_W-1:0] PIX_FG = 8'hFF;
    localparam logic [TH_PIX_W-1:0] PIX_BG = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [TH_PIX_W-1:0]  data;
        logic [TH_ADDR_W-1:0] addr;
        logic                 eol;
    } res_entry_t;

    // Unsigned compare: a pixel equal to the threshold counts as foreground.
    function automatic logic [TH_PIX_W-1:0] binarise(input logic [TH_PIX_W-1:0] pix,
                                                     input logic [TH_PIX_W-1:0] thr);
        return (pix >= thr) ? PIX_FG : PIX_BG;
    endfunction

endpackage

// File: rtl/threshold_result_fifo.sv
// Two-entry synchronous FIFO holding binarised results ahead of the
// output memory.
// Ports:
//   clk, reset     : clock and asynchronous active-high reset
//   push_i, entry_i: write request and entry to store
//   pop_i          : read request (head advances when not empty)
//   head_o         : oldest stored entry
//   full_o, empty_o, count_o : occupancy status
// A push is accepted while full only if a pop happens in the same cycle.
module threshold_result_fifo
    import threshold_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  res_entry_t entry_i,
    input  logic       pop_i,
    output res_entry_t head_o,
    output logic       full_o,
    output logic       empty_o,
    output logic [1:0] count_o
);

    res_entry_t mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       do_push;
    logic       do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    // Occupancy only changes when exactly one of push/pop happens.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 2'd1;
        end
    end

    // Storage and pointers; each pointer toggles between the two slots.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= entry_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/threshold_frame_ctrl.sv
// Sequencer for one full-frame binarisation pass. Reads pixels in raster
// order, compares each against a threshold latched at start, and writes
// 8'hFF / 8'h00 results through a 2-entry buffer with ready/valid
// backpressure.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   start, threshold_in: frame start request and threshold (sampled on accept)
//   busy, done         : frame in progress / one-cycle completion pulse
//   rd_en, rd_addr     : input memory read strobe and linear address
//   rd_data            : pixel returned one cycle after rd_en
//   wr_valid, wr_ready : output write handshake
//   wr_addr, wr_data   : output linear address and binarised pixel
//   wr_eol             : last pixel of a row
//   fg_count           : foreground pixels written (only with THRESHOLD_FG_COUNT_EN)
// Optional feature macro: THRESHOLD_FG_COUNT_EN.
module threshold_frame_ctrl
    import threshold_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 768,
    parameter int IMAGE_HEIGHT = 512,
    parameter int PIX_W        = TH_PIX_W,
    parameter int ADDR_W       = TH_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PIX_W-1:0]  threshold_in,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              wr_eol
`ifdef THRESHOLD_FG_COUNT_EN
    ,
    output logic [ADDR_W:0]   fg_count
`endif
);

    localparam int                NPIX      = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int                COL_W     = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMAGE_WIDTH - 1);

    state_t            state_q, state_d;
    logic [PIX_W-1:0]  thr_q, thr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              inflight_q;

    res_entry_t        push_entry;
    res_entry_t        head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_count;
    logic              accept;
    logic [1:0]        occ;

    assign accept = wr_valid && wr_ready;

    // Occupancy seen by the issue rule counts an entry leaving this cycle
    // as already gone; otherwise a steady 1 pixel/cycle stream is impossible
    // because the head is always still registered when the next read decides.
    assign occ   = fifo_count - {1'b0, accept} + {1'b0, inflight_q};
    assign rd_en = (state_q == RUN) && (occ < 2'd2) && !(fifo_full && !accept);

    // The returning pixel belongs to the read issued last cycle, whose
    // address is one behind the read pointer. Results leave the buffer in
    // the same order they enter, so the column counter advancing on each
    // push is the column of the matching write.
    always_comb begin
        push_entry      = '0;
        push_entry.data = binarise(rd_data, thr_q);
        push_entry.addr = rd_addr_q - ADDR_W'(1);
        push_entry.eol  = (col_q == LAST_COL);
    end

    threshold_result_fifo u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (inflight_q),
        .entry_i (push_entry),
        .pop_i   (accept),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Next-state logic: the start branch is last so its counter clears
    // override anything else written in the same cycle.
    always_comb begin
        state_d   = state_q;
        thr_d     = thr_q;
        rd_addr_d = rd_addr_q;
        col_d     = col_q;
        if (inflight_q) begin
            col_d = (col_q == LAST_COL) ? '0 : col_q + COL_W'(1);
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    thr_d     = threshold_in;
                    rd_addr_d = '0;
                    col_d     = '0;
                end
            end
            RUN: begin
                if (rd_en) begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (accept && (head.addr == LAST_ADDR)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer registers; a reset mid-frame simply abandons the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            thr_q      <= '0;
            rd_addr_q  <= '0;
            col_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            thr_q      <= thr_d;
            rd_addr_q  <= rd_addr_d;
            col_q      <= col_d;
            inflight_q <= rd_en;
        end
    end

    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign done     = (state_q == DONE);
    assign rd_addr  = rd_addr_q;
    assign wr_valid = !fifo_empty;
    assign wr_addr  = wr_valid ? head.addr : '0;
    assign wr_data  = wr_valid ? head.data : '0;
    assign wr_eol   = wr_valid && head.eol;

`ifdef THRESHOLD_FG_COUNT_EN
    logic [ADDR_W:0] fg_q, fg_d;

    // Foreground tally: cleared by an accepted start, held after done.
    always_comb begin
        fg_d = fg_q;
        if ((state_q == IDLE) && start) begin
            fg_d = '0;
        end else if (accept && (wr_data == PIX_FG)) begin
            fg_d = fg_q + (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fg_q <= '0;
        end else begin
            fg_q <= fg_d;
        end
    end

    assign fg_count = fg_q;
`endif

endmodule

// File: tb/tb_threshold_frame_ctrl.sv
// Directed self-checking bench for threshold_frame_ctrl on a 4x2 frame.
// A small memory model answers reads one cycle after rd_en; a negedge
// monitor records accepted writes, handshake timing and issue-rule
// violations; the main initial block drives directed frames and compares
// against hand-computed results.
module tb_threshold_frame_ctrl;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int N  = W * H;
    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    threshold_in;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data = 8'h00;
    logic          wr_valid;
    logic          wr_ready = 1'b1;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_eol;
`ifdef THRESHOLD_FG_COUNT_EN
    logic [AW:0]   fg_count;
`endif

    threshold_frame_ctrl #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .PIX_W        (8),
        .ADDR_W       (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .threshold_in (threshold_in),
        .busy         (busy),
        .done         (done),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_eol       (wr_eol)
`ifdef THRESHOLD_FG_COUNT_EN
        ,
        .fg_count     (fg_count)
`endif
    );

    always #5 clk = ~clk;

    // Input pixel memory with a fixed one-cycle read latency.
    logic [7:0] pixMem [N];
    always @(posedge clk) begin
        rd_data <= (rd_en && (rd_addr < AW'(N))) ? pixMem[rd_addr[2:0]] : 8'h00;
    end

    // Output-side ready pattern: 0 = always ready, 1 = random, 2 = stalled.
    int readyMode = 0;
    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       wr_ready = 1'b1;
            1:       wr_ready = 1'($urandom_range(0, 1));
            default: wr_ready = 1'b0;
        endcase
    end

    int   cyc = 0;
    int   issued = 0;
    int   accepted = 0;
    int   doneCount = 0;
    int   doneSeen = 0;
    int   ruleViol = 0;
    int   startCyc = 0;
    int   firstRdCyc = 0;
    int   firstValidCyc = 0;
    int   lastAccCyc = 0;
    int   doneCyc = 0;
    bit   gotRd = 1'b0;
    bit   gotValid = 1'b0;
    bit   busyAtDone = 1'b0;
    int   outAddr [$];
    logic [7:0] outData [$];
    bit   outEol [$];

    int   checkCount = 0;
    int   passCount = 0;

    // Monitor: samples mid-cycle, after all edge activity has settled.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            issued   = 0;
            accepted = 0;
        end else begin
            if (start && !busy && !done) begin
                startCyc = cyc;
                gotRd    = 1'b0;
                gotValid = 1'b0;
            end
            if (rd_en && !gotRd) begin
                gotRd      = 1'b1;
                firstRdCyc = cyc;
            end
            if (wr_valid && !gotValid) begin
                gotValid      = 1'b1;
                firstValidCyc = cyc;
            end
            if (rd_en && ((issued - accepted - int'(wr_valid && wr_ready)) >= 2)) begin
                ruleViol++;
            end
            if (rd_en) begin
                issued++;
            end
            if (wr_valid && wr_ready) begin
                outAddr.push_back(int'(wr_addr));
                outData.push_back(wr_data);
                outEol.push_back(wr_eol);
                accepted++;
                lastAccCyc = cyc;
            end
            if (done) begin
                doneCount++;
                doneCyc    = cyc;
                busyAtDone = busy;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    // Clears the capture queues and issues a one-cycle start; threshold_in
    // is scrambled afterwards so only the latched value can be in use.
    task automatic applyStimulus(input logic [7:0] thr);
        outAddr.delete();
        outData.delete();
        outEol.delete();
        @(posedge clk); #1;
        start        = 1'b1;
        threshold_in = thr;
        @(posedge clk); #1;
        start        = 1'b0;
        threshold_in = ~thr;
    endtask

    task automatic pulseStart(input logic [7:0] thr);
        start        = 1'b1;
        threshold_in = thr;
        @(posedge clk); #1;
        start        = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        int n = 0;
        while ((doneCount == doneSeen) && (n < 500)) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({tag, " done pulses"}, doneCount - doneSeen, 1);
        doneSeen = doneCount;
        @(posedge clk); #1;
    endtask

    task automatic checkFrame(input string tag, input logic [7:0] expData [N]);
        checkOutput({tag, " write count"}, outData.size(), N);
        for (int i = 0; i < N; i++) begin
            if (i < outData.size()) begin
                checkOutput($sformatf("%s addr[%0d]", tag, i), outAddr[i], i);
                checkOutput($sformatf("%s data[%0d]", tag, i), outData[i], expData[i]);
                checkOutput($sformatf("%s eol[%0d]", tag, i), outEol[i], (i % W) == (W - 1));
            end
        end
    endtask

    logic [7:0] expV [N];
    logic [7:0] rThr;
    int         n;
    int         baseIss;
    int         baseAcc;
    int         doneBefore;

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        threshold_in = 8'h00;
        for (int i = 0; i < N; i++) pixMem[i] = 8'h00;
        #1;
        checkOutput("reset ctrl bits", {busy, done, rd_en, wr_valid, wr_eol}, 0);
        checkOutput("reset rd_addr", rd_addr, 0);
        checkOutput("reset wr_addr", wr_addr, 0);
        checkOutput("reset wr_data", wr_data, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Ramp 0,30,...,210 at threshold 100, always ready.
        for (int i = 0; i < N; i++) pixMem[i] = 8'(i * 30);
        applyStimulus(8'd100);
        waitDone("ramp");
        expV = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        checkFrame("ramp", expV);
        checkOutput("first rd_en latency", firstRdCyc - startCyc, 1);
        checkOutput("first wr_valid latency", firstValidCyc - startCyc, 3);
        checkOutput("done after last accept", doneCyc - lastAccCyc, 1);
        checkOutput("full-rate frame length", doneCyc - startCyc, 11);
        checkOutput("busy low at done", busyAtDone, 0);

        // Boundary thresholds.
        for (int i = 0; i < N; i++) pixMem[i] = 8'd255;
        applyStimulus(8'd0);
        waitDone("thr0");
        expV = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        checkFrame("thr0 on 255", expV);
        applyStimulus(8'd255);
        waitDone("thr255");
        checkFrame("thr255 on 255", expV);
        for (int i = 0; i < N; i++) pixMem[i] = 8'd254;
        applyStimulus(8'd255);
        waitDone("thr255 254");
        expV = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        checkFrame("thr255 on 254", expV);

        // Mid-row stall with an ignored start in RUN, then in DRAIN.
        for (int i = 0; i < N; i++) pixMem[i] = 8'(i * 30);
        applyStimulus(8'd100);
        baseIss = issued;
        baseAcc = accepted;
        n = 0;
        while (((accepted - baseAcc) < 2) && (n < 200)) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("stall point reached", n < 200, 1);
        readyMode = 2;
        pulseStart(8'd0);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("stall outstanding", issued - accepted, 2);
        checkOutput("stall rd_en", rd_en, 0);
        checkOutput("stall wr_valid", wr_valid, 1);
        checkOutput("stall busy", busy, 1);
        readyMode = 0;
        n = 0;
        while (((issued - baseIss) < N) && (n < 200)) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("drain point reached", n < 200, 1);
        readyMode = 2;
        pulseStart(8'd0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("drain busy", busy, 1);
        checkOutput("drain rd_en", rd_en, 0);
        checkOutput("drain wr_valid", wr_valid, 1);
        readyMode = 0;
        waitDone("stall");
        expV = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        checkFrame("stall", expV);

        // Reset at pixel 5 aborts the frame with no done pulse.
        applyStimulus(8'd100);
        baseIss = issued;
        n = 0;
        while (((issued - baseIss) < 5) && (n < 200)) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("reset point reached", n < 200, 1);
        doneBefore = doneCount;
        reset = 1'b1;
        #1;
        checkOutput("midreset ctrl bits", {busy, done, rd_en, wr_valid, wr_eol}, 0);
        checkOutput("midreset rd_addr", rd_addr, 0);
        checkOutput("midreset wr_addr", wr_addr, 0);
        checkOutput("midreset wr_data", wr_data, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("no done after reset", doneCount - doneBefore, 0);
        doneSeen = doneCount;
        applyStimulus(8'd60);
        waitDone("post reset");
        expV = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        checkFrame("post reset", expV);
        checkOutput("post reset latency", firstValidCyc - startCyc, 3);

        // Random backpressure over several frames of random data.
        readyMode = 1;
        for (int f = 0; f < 4; f++) begin
            rThr = 8'($urandom_range(0, 255));
            for (int i = 0; i < N; i++) begin
                pixMem[i] = 8'($urandom_range(0, 255));
                expV[i]   = (pixMem[i] >= rThr) ? 8'hFF : 8'h00;
            end
            applyStimulus(rThr);
            waitDone($sformatf("random%0d", f));
            checkFrame($sformatf("random%0d", f), expV);
        end
        readyMode = 0;
        checkOutput("issue rule violations", ruleViol, 0);

`ifdef THRESHOLD_FG_COUNT_EN
        pixMem = '{8'd10, 8'd200, 8'd20, 8'd150, 8'd30, 8'd40, 8'd100, 8'd5};
        applyStimulus(8'd100);
        waitDone("fg");
        expV = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00};
        checkFrame("fg", expV);
        checkOutput("fg_count at done", fg_count, 3);
        applyStimulus(8'd100);
        checkOutput("fg_count cleared on start", fg_count, 0);
        waitDone("fg again");
        checkOutput("fg_count second frame", fg_count, 3);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
